// File: rtl/axil_bus_pkg.sv
// rtl/axil_bus_pkg.sv - shared state encodings and AXI response codes for the bus arbiter
package axil_bus_pkg;

  typedef enum logic [1:0] {
    W_IDLE,
    W_REQ,
    W_RESP
  } w_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_ADDR,
    R_DATA
  } r_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axil_rr_arbiter.sv
// rtl/axil_rr_arbiter.sv - round-robin request picker; pointer moves only when the owner finishes
module axil_rr_arbiter #(
  parameter  int NUM_MASTERS = 2,
  localparam int IDX_W       = $clog2(NUM_MASTERS)
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [NUM_MASTERS-1:0] req,
  input  logic                   advance,
  input  logic [IDX_W-1:0]       advance_idx,
  output logic                   grant_valid,
  output logic [IDX_W-1:0]       grant_idx
);

  logic [IDX_W-1:0] pointer;
  int               cand;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pointer <= IDX_W'(NUM_MASTERS - 1);
    end else if (advance) begin
      pointer <= advance_idx;
    end
  end

  // Search starts one past the last completed owner, so the previous winner goes last.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      cand = (int'(pointer) + k) % NUM_MASTERS;
      if (!grant_valid && req[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/axil_bus_arbiter.sv
// rtl/axil_bus_arbiter.sv - N-master to 1-slave AXI4-Lite arbiter with independent read/write paths
module axil_bus_arbiter
  import axil_bus_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic [NUM_MASTERS-1:0]          M_AWVALID,
  output logic [NUM_MASTERS-1:0]          M_AWREADY,
  input  logic [NUM_MASTERS*ADDR_W-1:0]   M_AWADDR,
  input  logic [NUM_MASTERS-1:0]          M_WVALID,
  output logic [NUM_MASTERS-1:0]          M_WREADY,
  input  logic [NUM_MASTERS*DATA_W-1:0]   M_WDATA,
  input  logic [NUM_MASTERS*DATA_W/8-1:0] M_WSTRB,
  output logic [NUM_MASTERS-1:0]          M_BVALID,
  input  logic [NUM_MASTERS-1:0]          M_BREADY,
  output logic [1:0]                      M_BRESP,
  input  logic [NUM_MASTERS-1:0]          M_ARVALID,
  output logic [NUM_MASTERS-1:0]          M_ARREADY,
  input  logic [NUM_MASTERS*ADDR_W-1:0]   M_ARADDR,
  output logic [NUM_MASTERS-1:0]          M_RVALID,
  input  logic [NUM_MASTERS-1:0]          M_RREADY,
  output logic [DATA_W-1:0]               M_RDATA,
  output logic [1:0]                      M_RRESP,
  output logic                            MEM_AWVALID,
  input  logic                            MEM_AWREADY,
  output logic [ADDR_W-1:0]               MEM_AWADDR,
  output logic                            MEM_WVALID,
  input  logic                            MEM_WREADY,
  output logic [DATA_W-1:0]               MEM_WDATA,
  output logic [DATA_W/8-1:0]             MEM_WSTRB,
  input  logic                            MEM_BVALID,
  output logic                            MEM_BREADY,
  input  logic [1:0]                      MEM_BRESP,
  output logic                            MEM_ARVALID,
  input  logic                            MEM_ARREADY,
  output logic [ADDR_W-1:0]               MEM_ARADDR,
  input  logic                            MEM_RVALID,
  output logic                            MEM_RREADY,
  input  logic [DATA_W-1:0]               MEM_RDATA,
  input  logic [1:0]                      MEM_RRESP
);

  localparam int IDX_W  = $clog2(NUM_MASTERS);
  localparam int STRB_W = DATA_W / 8;

  w_state_t         w_state, w_state_next;
  r_state_t         r_state, r_state_next;
  logic [IDX_W-1:0] w_grant, r_grant, w_arb_idx, r_arb_idx;
  logic             w_arb_valid, r_arb_valid;
  logic             aw_done, w_done, aw_hs, w_hs;
  logic             w_advance, r_advance;

  axil_rr_arbiter #(.NUM_MASTERS(NUM_MASTERS)) u_w_arb (
    .clock       (clock),
    .reset_n     (reset_n),
    .req         (M_AWVALID),
    .advance     (w_advance),
    .advance_idx (w_grant),
    .grant_valid (w_arb_valid),
    .grant_idx   (w_arb_idx)
  );

  axil_rr_arbiter #(.NUM_MASTERS(NUM_MASTERS)) u_r_arb (
    .clock       (clock),
    .reset_n     (reset_n),
    .req         (M_ARVALID),
    .advance     (r_advance),
    .advance_idx (r_grant),
    .grant_valid (r_arb_valid),
    .grant_idx   (r_arb_idx)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
      w_grant <= '0;
      r_grant <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      w_state <= w_state_next;
      r_state <= r_state_next;
      if (w_state == W_IDLE) begin
        w_grant <= w_arb_idx;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end else begin
        if (aw_hs) aw_done <= 1'b1;
        if (w_hs)  w_done  <= 1'b1;
      end
      if (r_state == R_IDLE) r_grant <= r_arb_idx;
    end
  end

  // AW and W are tracked separately so the slave may accept them in either order.
  always_comb begin
    w_state_next = w_state;
    MEM_AWVALID  = 1'b0;
    MEM_WVALID   = 1'b0;
    MEM_BREADY   = 1'b0;
    M_AWREADY    = '0;
    M_WREADY     = '0;
    M_BVALID     = '0;
    aw_hs        = 1'b0;
    w_hs         = 1'b0;
    w_advance    = 1'b0;
    case (w_state)
      W_IDLE: if (w_arb_valid) w_state_next = W_REQ;
      W_REQ: begin
        MEM_AWVALID         = !aw_done;
        MEM_WVALID          = M_WVALID[w_grant] && !w_done;
        M_AWREADY[w_grant]  = MEM_AWREADY && !aw_done;
        M_WREADY[w_grant]   = MEM_WVALID && MEM_WREADY;
        aw_hs               = MEM_AWVALID && MEM_AWREADY;
        w_hs                = MEM_WVALID && MEM_WREADY;
        if ((aw_done || aw_hs) && (w_done || w_hs)) w_state_next = W_RESP;
      end
      W_RESP: begin
        MEM_BREADY         = M_BREADY[w_grant];
        M_BVALID[w_grant]  = MEM_BVALID;
        if (MEM_BVALID && MEM_BREADY) begin
          w_advance    = 1'b1;
          w_state_next = W_IDLE;
        end
      end
      default: w_state_next = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_next = r_state;
    MEM_ARVALID  = 1'b0;
    MEM_RREADY   = 1'b0;
    M_ARREADY    = '0;
    M_RVALID     = '0;
    r_advance    = 1'b0;
    case (r_state)
      R_IDLE: if (r_arb_valid) r_state_next = R_ADDR;
      R_ADDR: begin
        MEM_ARVALID        = 1'b1;
        M_ARREADY[r_grant] = MEM_ARREADY;
        if (MEM_ARREADY) r_state_next = R_DATA;
      end
      R_DATA: begin
        MEM_RREADY        = M_RREADY[r_grant];
        M_RVALID[r_grant] = MEM_RVALID;
        if (MEM_RVALID && MEM_RREADY) begin
          r_advance    = 1'b1;
          r_state_next = R_IDLE;
        end
      end
      default: r_state_next = R_IDLE;
    endcase
  end

  assign MEM_AWADDR = M_AWADDR[int'(w_grant)*ADDR_W +: ADDR_W];
  assign MEM_WDATA  = M_WDATA[int'(w_grant)*DATA_W +: DATA_W];
  assign MEM_WSTRB  = M_WSTRB[int'(w_grant)*STRB_W +: STRB_W];
  assign MEM_ARADDR = M_ARADDR[int'(r_grant)*ADDR_W +: ADDR_W];
  assign M_BRESP    = MEM_BRESP;
  assign M_RDATA    = MEM_RDATA;
  assign M_RRESP    = MEM_RRESP;

endmodule

// File: tb/tb_axil_bus_arbiter.sv
// tb/tb_axil_bus_arbiter.sv - directed self-checking bench for axil_bus_arbiter with four masters
module tb_axil_bus_arbiter;
  import axil_bus_pkg::*;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic              clock = 1'b0;
  logic              reset_n;
  logic [N-1:0]      M_AWVALID, M_AWREADY, M_WVALID, M_WREADY, M_BVALID, M_BREADY;
  logic [N-1:0]      M_ARVALID, M_ARREADY, M_RVALID, M_RREADY;
  logic [N*AW-1:0]   M_AWADDR, M_ARADDR;
  logic [N*DW-1:0]   M_WDATA;
  logic [N*DW/8-1:0] M_WSTRB;
  logic [1:0]        M_BRESP, M_RRESP, MEM_BRESP, MEM_RRESP;
  logic [DW-1:0]     M_RDATA, MEM_WDATA, MEM_RDATA;
  logic [AW-1:0]     MEM_AWADDR, MEM_ARADDR;
  logic [DW/8-1:0]   MEM_WSTRB;
  logic              MEM_AWVALID, MEM_AWREADY, MEM_WVALID, MEM_WREADY, MEM_BVALID, MEM_BREADY;
  logic              MEM_ARVALID, MEM_ARREADY, MEM_RVALID, MEM_RREADY;
  logic [24:0]       hs_outs;

  int tests_run = 0;
  int failed    = 0;
  int w_beats, aw_beats, b_beats, bad;

  always #5 clock = ~clock;

  assign hs_outs = {M_AWREADY, M_WREADY, M_BVALID, M_ARREADY, M_RVALID,
                    MEM_AWVALID, MEM_WVALID, MEM_BREADY, MEM_ARVALID, MEM_RREADY};

  axil_bus_arbiter #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .M_AWVALID   (M_AWVALID),
    .M_AWREADY   (M_AWREADY),
    .M_AWADDR    (M_AWADDR),
    .M_WVALID    (M_WVALID),
    .M_WREADY    (M_WREADY),
    .M_WDATA     (M_WDATA),
    .M_WSTRB     (M_WSTRB),
    .M_BVALID    (M_BVALID),
    .M_BREADY    (M_BREADY),
    .M_BRESP     (M_BRESP),
    .M_ARVALID   (M_ARVALID),
    .M_ARREADY   (M_ARREADY),
    .M_ARADDR    (M_ARADDR),
    .M_RVALID    (M_RVALID),
    .M_RREADY    (M_RREADY),
    .M_RDATA     (M_RDATA),
    .M_RRESP     (M_RRESP),
    .MEM_AWVALID (MEM_AWVALID),
    .MEM_AWREADY (MEM_AWREADY),
    .MEM_AWADDR  (MEM_AWADDR),
    .MEM_WVALID  (MEM_WVALID),
    .MEM_WREADY  (MEM_WREADY),
    .MEM_WDATA   (MEM_WDATA),
    .MEM_WSTRB   (MEM_WSTRB),
    .MEM_BVALID  (MEM_BVALID),
    .MEM_BREADY  (MEM_BREADY),
    .MEM_BRESP   (MEM_BRESP),
    .MEM_ARVALID (MEM_ARVALID),
    .MEM_ARREADY (MEM_ARREADY),
    .MEM_ARADDR  (MEM_ARADDR),
    .MEM_RVALID  (MEM_RVALID),
    .MEM_RREADY  (MEM_RREADY),
    .MEM_RDATA   (MEM_RDATA),
    .MEM_RRESP   (MEM_RRESP)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    M_AWVALID = '0; M_WVALID = '0; M_BREADY = '0; M_ARVALID = '0; M_RREADY = '0;
    MEM_AWREADY = 1'b0; MEM_WREADY = 1'b0; MEM_BVALID = 1'b0; MEM_BRESP = RESP_OKAY;
    MEM_ARREADY = 1'b0; MEM_RVALID = 1'b0; MEM_RDATA = '0; MEM_RRESP = RESP_OKAY;
    for (int i = 0; i < N; i++) begin
      M_AWADDR[i*AW +: AW]     = 32'h1000 + 32'(i) * 16;
      M_ARADDR[i*AW +: AW]     = 32'h2000 + 32'(i) * 16;
      M_WDATA[i*DW +: DW]      = 32'hA000_0000 + 32'(i);
      M_WSTRB[i*DW/8 +: DW/8]  = 4'hF;
    end
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 1'b0;
    @(negedge clock); #1;
    check("reset_outs", 64'(hs_outs), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  // One full write with every slave channel ready; called right at a negedge in W_IDLE.
  task automatic write_round(input logic [N-1:0] mask, input logic [N-1:0] exp_grant,
                             input int exp_idx, input string tag);
    logic [N-1:0] g;
    int n;
    M_AWVALID = mask; M_WVALID = mask; MEM_AWREADY = 1'b1; MEM_WREADY = 1'b1;
    M_BREADY = '1; MEM_BVALID = 1'b0;
    n = 0;
    do begin
      @(negedge clock); #1;
      n++;
    end while (!MEM_AWVALID && n < 8);
    check({tag, "_grant"}, 64'(M_AWREADY), 64'(exp_grant));
    check({tag, "_addr"}, 64'(MEM_AWADDR), 64'(32'h1000 + exp_idx * 16));
    g = M_AWREADY;
    @(negedge clock);
    M_AWVALID = M_AWVALID & ~g; M_WVALID = M_WVALID & ~g; MEM_BVALID = 1'b1; #1;
    check({tag, "_b"}, 64'(M_BVALID), 64'(exp_grant));
    @(negedge clock);
    MEM_BVALID = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1) single write from M0
    do_reset();
    M_AWADDR[31:0] = 32'h100; M_WDATA[31:0] = 32'hDEADBEEF; M_WSTRB[3:0] = 4'hF;
    M_AWVALID = 4'b0001; M_WVALID = 4'b0001; MEM_AWREADY = 1'b1; MEM_WREADY = 1'b1;
    M_BREADY = 4'b0001; #1;
    check("t1_no_aw_first_cycle", 64'(MEM_AWVALID), 64'd0);
    @(negedge clock); #1;
    check("t1_mem_valids", 64'({MEM_AWVALID, MEM_WVALID}), 64'b11);
    check("t1_mem_awaddr", 64'(MEM_AWADDR), 64'h100);
    check("t1_mem_wdata", 64'({MEM_WSTRB, MEM_WDATA}), {28'd0, 4'hF, 32'hDEADBEEF});
    check("t1_m_ready", 64'({M_AWREADY, M_WREADY}), 64'b0001_0001);
    @(negedge clock);
    M_AWVALID = '0; M_WVALID = '0; #1;
    check("t1_b_wait", 64'({M_BVALID, MEM_AWVALID, MEM_WVALID, MEM_BREADY}), 64'b0000_0_0_1);
    @(negedge clock);
    MEM_BVALID = 1'b1; MEM_BRESP = RESP_SLVERR; #1;
    check("t1_bvalid", 64'({M_BVALID, M_BRESP}), 64'b0001_10);
    @(negedge clock);
    MEM_BVALID = 1'b0; #1;
    check("t1_b_done", 64'(M_BVALID), 64'd0);

    // 2) round-robin order
    do_reset();
    write_round(4'b0011, 4'b0001, 0, "t2_a");
    write_round(4'b0011, 4'b0010, 1, "t2_b");
    write_round(4'b0011, 4'b0001, 0, "t2_c");
    write_round(4'b0011, 4'b0010, 1, "t2_d");
    do_reset();
    write_round(4'b1111, 4'b0001, 0, "t2_all0");
    write_round(4'b1111, 4'b0010, 1, "t2_all1");
    write_round(4'b1111, 4'b0100, 2, "t2_all2");
    write_round(4'b1111, 4'b1000, 3, "t2_all3");
    write_round(4'b1111, 4'b0001, 0, "t2_all4");

    // 3) M1 write concurrent with M0 read
    do_reset();
    M_AWVALID = 4'b0010; M_WVALID = 4'b0010; M_ARVALID = 4'b0001; M_ARADDR[31:0] = 32'h200;
    MEM_AWREADY = 1'b1; MEM_WREADY = 1'b1; MEM_ARREADY = 1'b1; M_BREADY = '1; M_RREADY = '1;
    @(negedge clock); #1;
    check("t3_req", 64'({M_AWREADY, M_ARREADY, MEM_AWVALID, MEM_ARVALID}), 64'b0010_0001_11);
    check("t3_addrs", {MEM_AWADDR, MEM_ARADDR}, {32'h1010, 32'h200});
    @(negedge clock);
    M_AWVALID = '0; M_WVALID = '0; M_ARVALID = '0;
    MEM_RVALID = 1'b1; MEM_RDATA = 32'hCAFE0200; MEM_RRESP = RESP_SLVERR; MEM_BVALID = 1'b1; #1;
    check("t3_rvalid", 64'(M_RVALID), 64'b0001);
    check("t3_rdata", 64'({M_RRESP, M_RDATA}), {30'd0, 2'b10, 32'hCAFE0200});
    check("t3_bvalid", 64'(M_BVALID), 64'b0010);
    @(negedge clock);
    MEM_RVALID = 1'b0; MEM_BVALID = 1'b0; #1;
    check("t3_done", 64'({M_RVALID, M_BVALID}), 64'd0);

    // 4) W accepted three cycles before AW
    do_reset();
    M_AWVALID = 4'b0001; M_WVALID = 4'b0001; MEM_WREADY = 1'b1; M_BREADY = 4'b0001;
    w_beats = 0; aw_beats = 0; b_beats = 0;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clock);
      MEM_AWREADY = (c == 4);
      if (c == 5) begin
        M_AWVALID = '0; M_WVALID = '0; MEM_BVALID = 1'b1;
      end
      if (c == 6) MEM_BVALID = 1'b0;
      #1;
      w_beats  += int'(MEM_WVALID && MEM_WREADY);
      aw_beats += int'(MEM_AWVALID && MEM_AWREADY);
      b_beats  += int'(M_BVALID[0] && M_BREADY[0]);
    end
    check("t4_w_beats", 64'(w_beats), 64'd1);
    check("t4_aw_beats", 64'(aw_beats), 64'd1);
    check("t4_b_beats", 64'(b_beats), 64'd1);

    // 5) B stalled by the master blocks new write grants
    do_reset();
    M_AWVALID = 4'b0001; M_WVALID = 4'b0001; MEM_AWREADY = 1'b1; MEM_WREADY = 1'b1;
    @(negedge clock);
    @(negedge clock);
    M_AWVALID = 4'b0010; M_WVALID = 4'b0010; MEM_BVALID = 1'b1;
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (M_BVALID !== 4'b0001 || MEM_BREADY !== 1'b0 || M_AWREADY !== 4'b0000 || MEM_AWVALID !== 1'b0)
        bad++;
      @(negedge clock);
    end
    check("t5_b_held", 64'(bad), 64'd0);
    M_BREADY = 4'b0001; #1;
    check("t5_b_release", 64'({M_BVALID, MEM_BREADY}), 64'b0001_1);
    @(negedge clock);
    MEM_BVALID = 1'b0; M_BREADY = '0;
    @(negedge clock); #1;
    check("t5_next_grant", 64'(M_AWREADY), 64'b0010);

    // 6) asynchronous reset during W_REQ
    do_reset();
    write_round(4'b0001, 4'b0001, 0, "t6_pre");
    M_AWVALID = 4'b0011; M_WVALID = 4'b0011; MEM_AWREADY = 1'b0; MEM_WREADY = 1'b0;
    @(negedge clock); #1;
    check("t6_grant_m1", 64'({MEM_AWVALID, MEM_AWADDR}), {31'd0, 1'b1, 32'h1010});
    #2 reset_n = 1'b0;
    #1 check("t6_async_reset", 64'(hs_outs), 64'd0);
    @(negedge clock);
    reset_n = 1'b1; MEM_AWREADY = 1'b1; MEM_WREADY = 1'b1;
    @(negedge clock); #1;
    check("t6_m0_first", 64'(M_AWREADY), 64'b0001);

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
